lcd_rect_span_sequencer: RTL
============================

// Module: lcd_rect_span_sequencer
// PURPOSE
//  Upstream command stage for the LCD SDRAM pixel writer. Accepts one rectangle-fill
//  command (x, y, w, h, colour) over a valid/ready handshake, clips it to the display,
//  and issues one horizontal span per row on the writer's enable/busy interface
//  (x_pos, y_pos, len, pixel, enable). Reports completion, rejection and timeout.
// PARAMETERS
//  H_DISP      1024  visible width in pixels; x >= H_DISP is off-screen
//  V_DISP      600   visible height in lines; y >= V_DISP is off-screen
//  BUSY_TMO    1023  max cycles from enable high to busy seen high; counter is 10 bits
//  GAP_CYC     2     idle cycles with enable low between consecutive row spans (>=1)
// PORTS
//  clk          in   1   system clock, same domain as the writer
//  rst_n        in   1   asynchronous active-low reset
//  sys_vaild    in   1   SDRAM ready; no span is issued while low
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   high only in IDLE; transfer when cmd_valid & cmd_ready
//  cmd_x        in   16  top-left x
//  cmd_y        in   16  top-left y
//  cmd_w        in   16  width in pixels
//  cmd_h        in   16  height in lines
//  cmd_color    in   24  RGB888 fill colour
//  span_x       out  16  writer x_pos
//  span_y       out  16  writer y_pos
//  span_len     out  24  writer len; clipped width zero-extended
//  span_pixel   out  24  writer pixel; latched cmd_color
//  span_enable  out  1   writer enable
//  span_busy    in   1   writer busy
//  done         out  1   1-cycle pulse when a command retires, including reject and abort
//  rejected     out  1   valid with done: command fully off-screen or w==0 or h==0
//  timeout      out  1   valid with done: writer never raised busy within BUSY_TMO
// BEHAVIOUR
//  Reset: cmd_ready=0, span_*=0, span_enable=0, done=rejected=timeout=0, state=IDLE.
//   Reset is asynchronous and may occur mid-command: the command is abandoned with no
//   done pulse. cmd_ready rises the first cycle after reset release.
//  FSM states: IDLE, CLIP, ARM, WAIT_BUSY, WAIT_DONE, GAP, RETIRE.
//  IDLE: cmd_ready=1. On handshake, latch all cmd_* fields -> CLIP.
//  CLIP (1 cycle): if x>=H_DISP | y>=V_DISP | w==0 | h==0, go to RETIRE with
//   rejected=1. Otherwise w_eff=min(w, H_DISP-x) and h_eff=min(h, V_DISP-y), both
//   computed in 17 bits with no wrap. row=0 -> ARM.
//  ARM: wait for sys_vaild=1 & span_busy=0. Then drive span_x=x, span_y=y+row,
//   span_len=w_eff, span_pixel=colour; span_enable=1; clear tmo counter -> WAIT_BUSY.
//  WAIT_BUSY: hold span_* and enable stable. span_busy=1: enable=0 next cycle ->
//   WAIT_DONE. Counter reaches BUSY_TMO: enable=0 -> RETIRE with timeout=1; remaining
//   rows are dropped.
//  WAIT_DONE: enable stays low so the writer clears its done latch. span_busy=0 ->
//   row++. If row==h_eff go to RETIRE, else go to GAP.
//  GAP: keep enable low for GAP_CYC cycles -> ARM.
//  RETIRE: done=1 for exactly one cycle with flags valid; flags return to 0 next
//   cycle -> IDLE.
//  span_enable never stays high after busy has been seen. span_* change only in ARM.
//  sys_vaild dropping mid-row does not abort; the FSM keeps waiting on busy.
//  Minimum per-row overhead: 1 ARM + 1 WAIT_BUSY + writer time + GAP_CYC.
// STRUCTURE
//  Shared package lcd_pkg:
//   - H_DISP/V_DISP defaults
//   - colour constants (GREEN etc., shared with the writer)
//   - FSM state encoding localparams
//   - span record field widths (16/16/24/24)
//  Optional sub-module lcd_rect_clip: combinational clip and reject logic, unit-testable
//   on its own. Everything else is a single FSM plus row and timeout counters.
// TESTING
//  Bench pairs the block with a behavioural writer model: busy rises 3 cycles after
//  enable and stays high len+2 cycles.
//  1 cmd (10,20,w=5,h=3,0x00FF00) -> 3 spans y=20,21,22, x=10, len=5; 1 done; flags 0
//  2 cmd x=1020,w=10,y=598,h=5 -> 2 spans (y=598,599), len=4; done
//  3 cmd x=1024 or h=0 -> no span_enable; done & rejected 2 cycles after handshake
//  4 model never raises busy -> enable drops after 1023 cycles; done & timeout; cmd_ready=1
//  5 sys_vaild held low 50 cycles after handshake -> span_enable stays 0 until it rises
//  6 rst_n low during row 2 -> all outputs 0 immediately; no done; next cmd runs cleanly

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel-writer command path.
package lcd_pkg;

  // Default display geometry
  localparam int unsigned H_DISP_DEF   = 1024;
  localparam int unsigned V_DISP_DEF   = 600;

  // Default sequencer timing
  localparam int unsigned BUSY_TMO_DEF = 1023;
  localparam int unsigned GAP_CYC_DEF  = 2;

  // Span record field widths
  localparam int unsigned SPAN_X_W   = 16;
  localparam int unsigned SPAN_Y_W   = 16;
  localparam int unsigned SPAN_LEN_W = 24;
  localparam int unsigned SPAN_PIX_W = 24;

  // RGB888 colour constants shared with the writer
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  // Span sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLIP,
    ST_ARM,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP,
    ST_RETIRE
  } seq_state_t;

endpackage

// File: rtl/lcd_rect_span_sequencer_if.sv
// Command handshake and writer span bus of the rectangle span sequencer.
// slave: the sequencer itself; master: command source plus pixel writer.
interface lcd_rect_span_sequencer_if;
  import lcd_pkg::*;

  logic                  sys_vaild;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [15:0]           cmd_x;
  logic [15:0]           cmd_y;
  logic [15:0]           cmd_w;
  logic [15:0]           cmd_h;
  logic [23:0]           cmd_color;
  logic [SPAN_X_W-1:0]   span_x;
  logic [SPAN_Y_W-1:0]   span_y;
  logic [SPAN_LEN_W-1:0] span_len;
  logic [SPAN_PIX_W-1:0] span_pixel;
  logic                  span_enable;
  logic                  span_busy;
  logic                  done;
  logic                  rejected;
  logic                  timeout;

  modport slave (
    input  sys_vaild, cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, span_busy,
    output cmd_ready, span_x, span_y, span_len, span_pixel, span_enable,
    output done, rejected, timeout
  );

  modport master (
    output sys_vaild, cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, span_busy,
    input  cmd_ready, span_x, span_y, span_len, span_pixel, span_enable,
    input  done, rejected, timeout
  );

endinterface

// File: rtl/lcd_rect_clip.sv
// Combinational clip of a rectangle against the visible display area.
module lcd_rect_clip
  import lcd_pkg::*;
#(
  parameter int unsigned H_DISP = H_DISP_DEF,
  parameter int unsigned V_DISP = V_DISP_DEF
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] w,
  input  logic [15:0] h,
  output logic        reject,
  output logic [16:0] w_eff,
  output logic [16:0] h_eff
);

  logic [16:0] room_x;
  logic [16:0] room_y;

  // Reject off-screen or empty rectangles; clamp extent to the remaining room
  always_comb begin
    reject = ({1'b0, x} >= 17'(H_DISP)) || ({1'b0, y} >= 17'(V_DISP)) ||
             (w == '0) || (h == '0);
    room_x = 17'(H_DISP) - {1'b0, x};
    room_y = 17'(V_DISP) - {1'b0, y};
    w_eff  = ({1'b0, w} < room_x) ? {1'b0, w} : room_x;
    h_eff  = ({1'b0, h} < room_y) ? {1'b0, h} : room_y;
  end

endmodule

// File: rtl/lcd_rect_span_sequencer.sv
// Rectangle-fill command sequencer: clips the rectangle and issues one
// horizontal span per row to the SDRAM pixel writer.
module lcd_rect_span_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned H_DISP   = H_DISP_DEF,
  parameter int unsigned V_DISP   = V_DISP_DEF,
  parameter int unsigned BUSY_TMO = BUSY_TMO_DEF,
  parameter int unsigned GAP_CYC  = GAP_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  lcd_rect_span_sequencer_if.slave   bus
);

  localparam logic [9:0] TMO_LAST = 10'(BUSY_TMO - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  seq_state_t state;

  logic [15:0] x_q, y_q, w_q, h_q;
  logic [23:0] color_q;
  logic [16:0] w_eff_q, h_eff_q;
  logic [16:0] row;
  logic [9:0]  tmo_cnt;
  logic [7:0]  gap_cnt;

  logic                  cmd_ready_q;
  logic [SPAN_X_W-1:0]   span_x_q;
  logic [SPAN_Y_W-1:0]   span_y_q;
  logic [SPAN_LEN_W-1:0] span_len_q;
  logic [SPAN_PIX_W-1:0] span_pixel_q;
  logic                  span_enable_q;
  logic                  done_q, rejected_q, timeout_q;

  logic        clip_reject;
  logic [16:0] clip_w, clip_h;

  lcd_rect_clip #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP)
  ) u_clip (
    .x      (x_q),
    .y      (y_q),
    .w      (w_q),
    .h      (h_q),
    .reject (clip_reject),
    .w_eff  (clip_w),
    .h_eff  (clip_h)
  );

  // Command FSM with row, timeout and gap counters; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      color_q       <= '0;
      w_eff_q       <= '0;
      h_eff_q       <= '0;
      row           <= '0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      cmd_ready_q   <= 1'b0;
      span_x_q      <= '0;
      span_y_q      <= '0;
      span_len_q    <= '0;
      span_pixel_q  <= '0;
      span_enable_q <= 1'b0;
      done_q        <= 1'b0;
      rejected_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            x_q         <= bus.cmd_x;
            y_q         <= bus.cmd_y;
            w_q         <= bus.cmd_w;
            h_q         <= bus.cmd_h;
            color_q     <= bus.cmd_color;
            cmd_ready_q <= 1'b0;
            state       <= ST_CLIP;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_CLIP: begin
          w_eff_q <= clip_w;
          h_eff_q <= clip_h;
          row     <= '0;
          if (clip_reject) begin
            done_q     <= 1'b1;
            rejected_q <= 1'b1;
            state      <= ST_RETIRE;
          end else begin
            state <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (bus.sys_vaild && !bus.span_busy) begin
            span_x_q      <= x_q;
            span_y_q      <= y_q + row[15:0];
            span_len_q    <= SPAN_LEN_W'(w_eff_q);
            span_pixel_q  <= color_q;
            span_enable_q <= 1'b1;
            tmo_cnt       <= '0;
            state         <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          // busy wins over a simultaneous timeout expiry
          if (bus.span_busy) begin
            span_enable_q <= 1'b0;
            state         <= ST_WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            span_enable_q <= 1'b0;
            done_q        <= 1'b1;
            timeout_q     <= 1'b1;
            state         <= ST_RETIRE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.span_busy) begin
            row <= row + 17'd1;
            if (row + 17'd1 == h_eff_q) begin
              done_q <= 1'b1;
              state  <= ST_RETIRE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_ARM;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_RETIRE: begin
          done_q      <= 1'b0;
          rejected_q  <= 1'b0;
          timeout_q   <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.span_x      = span_x_q;
  assign bus.span_y      = span_y_q;
  assign bus.span_len    = span_len_q;
  assign bus.span_pixel  = span_pixel_q;
  assign bus.span_enable = span_enable_q;
  assign bus.done        = done_q;
  assign bus.rejected    = rejected_q;
  assign bus.timeout     = timeout_q;

endmodule
